// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter: default widths,
// FSM state encoding and the RAM strobe encodings {ram_we, ram_enable}.
package ram_arb_pkg;

  localparam int ADDR_W_DEFAULT = 4;
  localparam int DATA_W_DEFAULT = 8;

  // One transaction walks IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Strobe pair ordered {ram_we, ram_enable}.
  typedef logic [1:0] strobe_t;

  localparam strobe_t STROBE_OFF   = 2'b00;
  localparam strobe_t STROBE_WRITE = 2'b10;
  localparam strobe_t STROBE_READ  = 2'b01;

  // Strobe pair to raise during ACCESS for a latched transaction type.
  function automatic strobe_t strobe_for(input logic we);
    return we ? STROBE_WRITE : STROBE_READ;
  endfunction

endpackage

// File: rtl/ram_arb_if.sv
// Requester-side bundle of the RAM arbiter: two request channels and the
// shared response channel.
//
// Handshake: a request is transferred in the cycle where reqN_valid and
// reqN_ready are both high. The requester may raise valid at any time; ready
// is combinational and only high in IDLE for the requester that wins the
// grant. The response is a single-cycle rsp_valid pulse with no back-pressure.
interface ram_arb_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);

  logic              req0_valid;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;

  logic              req1_valid;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;

  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_rdata;

  // Requester side.
  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_rdata
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_rdata
  );

endinterface

// File: rtl/ram_arb_grant.sv
// Two-way grant selection. "last" names the requester granted most recently;
// on a conflict the other requester wins. A lone valid requester always wins.
module ram_arb_grant (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant, zero when nobody is requesting.
  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = last ? 2'b01 : 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of an external single-port RAM.
// Each accepted request takes four cycles: SETUP drives the address,
// ACCESS pulses the write or read strobe, RESP returns the completion.
// Optional feature macro RAM_ARB_RR_EN: round-robin conflict resolution.
// Without it requester 0 always wins a conflict and no pointer is kept.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  ram_arb_if.slave          bus,
  output logic              ram_we,
  output logic              ram_enable,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output state_t            fsm_state
);

  state_t            state;
  state_t            next_state;
  logic [1:0]        grant;
  logic              last_gnt;
  logic              hs;
  logic              hs_id;
  logic              we_q;
  logic              id_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  strobe_t           strobe;

`ifdef RAM_ARB_RR_EN
  logic last_q;

  // Remember who was granted last; reset favours requester 0 next.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (hs) begin
      last_q <= hs_id;
    end
  end

  assign last_gnt = last_q;
`else
  // Fixed priority: pretend requester 1 always went last.
  assign last_gnt = 1'b1;
`endif

  ram_arb_grant u_grant (
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .last   (last_gnt),
    .grant  (grant)
  );

  assign bus.req0_ready = (state == IDLE) && !rst && grant[0];
  assign bus.req1_ready = (state == IDLE) && !rst && grant[1];

  assign hs    = (bus.req0_valid && bus.req0_ready) ||
                 (bus.req1_valid && bus.req1_ready);
  assign hs_id = grant[1];

  assign sel_we    = hs_id ? bus.req1_we    : bus.req0_we;
  assign sel_addr  = hs_id ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = hs_id ? bus.req1_wdata : bus.req0_wdata;

  assign strobe = strobe_for(we_q);

  // The arbiter owns the data bus only while the write strobe is up.
  assign ram_data = (ram_we && !ram_enable) ? wdata_q : {DATA_W{1'bz}};

  assign fsm_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: only IDLE waits, the rest of the walk is unconditional.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (hs) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered RAM strobes, address and response, plus the latched request.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we        <= 1'b0;
      ram_enable    <= 1'b0;
      ram_addr      <= '0;
      we_q          <= 1'b0;
      id_q          <= 1'b0;
      wdata_q       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      ram_we        <= 1'b0;
      ram_enable    <= 1'b0;
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Address moves only here, while both strobes are low.
          if (hs) begin
            we_q     <= sel_we;
            id_q     <= hs_id;
            wdata_q  <= sel_wdata;
            ram_addr <= sel_addr;
          end
        end
        SETUP: begin
          {ram_we, ram_enable} <= strobe;
        end
        ACCESS: begin
          // Read data is captured at the end of the strobe cycle.
          bus.rsp_valid <= 1'b1;
          bus.rsp_id    <= id_q;
          bus.rsp_rdata <= we_q ? '0 : ram_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: external RAM model, cycle-level reference model of
// the four-cycle transaction, directed scenarios followed by random traffic.
// Build with +define+RAM_ARB_RR_EN to cover the round-robin policy.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          ram_we;
  logic          ram_enable;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;
  state_t        fsm_state;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ram_we     (ram_we),
    .ram_enable (ram_enable),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .fsm_state  (fsm_state)
  );

  // ---------------- external RAM ----------------
  logic [DW-1:0] ram_mem [16];
  logic          ram_clear;

  assign ram_data = (ram_enable && !ram_we) ? ram_mem[ram_addr] : {DW{1'bz}};

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= '0;
    end else if (ram_we && !ram_enable) begin
      ram_mem[ram_addr] <= ram_data;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic          id;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t          cur;
  int            age;           // cycles since acceptance, 0 = nothing in flight
  logic          last_gnt;
  logic [AW-1:0] exp_addr;
  logic          exp_rsp_id;
  logic [DW-1:0] exp_rsp_rdata;
  logic [DW-1:0] mem_m [16];
  logic [DW-1:0] exp_q [$];
  logic          rst_prev;
  bit            model_hs;
  int            cyc;
  int            dut_hs_cyc [$];
  int            dut_gnt [$];
  int            n_tests;
  int            n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check this cycle's outputs, then advance the model.
  task automatic tick();
    logic   v0, v1, win, idle_ok, e_r0, e_r1;
    state_t exp_st;
    #1;
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    if (v0 && v1) win = RR ? ~last_gnt : 1'b0;
    else          win = !v0 && v1;
    idle_ok = !rst && (age == 0) && (v0 || v1);
    e_r0 = idle_ok && !win;
    e_r1 = idle_ok && win;
    chk("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(e_r1));
    if ((v0 && bus.req0_ready) || (v1 && bus.req1_ready)) begin
      dut_hs_cyc.push_back(cyc);
      dut_gnt.push_back(bus.req1_ready ? 1 : 0);
    end
    // Registered outputs still show the pre-reset cycle when rst first rises.
    if (!(rst && !rst_prev)) begin
      case (age)
        1:       exp_st = SETUP;
        2:       exp_st = ACCESS;
        3:       exp_st = RESP;
        default: exp_st = IDLE;
      endcase
      chk("fsm_state",  32'(fsm_state),     32'(exp_st));
      chk("ram_we",     32'(ram_we),        32'(age == 2 && cur.we));
      chk("ram_enable", 32'(ram_enable),    32'(age == 2 && !cur.we));
      chk("ram_addr",   32'(ram_addr),      32'(exp_addr));
      chk("rsp_valid",  32'(bus.rsp_valid), 32'(age == 3));
      chk("rsp_id",     32'(bus.rsp_id),    32'(exp_rsp_id));
      chk("rsp_rdata",  32'(bus.rsp_rdata), 32'(exp_rsp_rdata));
      if (age == 2)
        chk("ram_data", 32'(ram_data), 32'(cur.we ? cur.data : mem_m[cur.addr]));
    end
    model_hs = idle_ok;
    if (model_hs) begin
      cur.id   = win;
      cur.we   = win ? bus.req1_we    : bus.req0_we;
      cur.addr = win ? bus.req1_addr  : bus.req0_addr;
      cur.data = win ? bus.req1_wdata : bus.req0_wdata;
      exp_q.push_back(cur.we ? '0 : mem_m[cur.addr]);
    end
    @(posedge clk);
    if (age == 2 && cur.we) mem_m[cur.addr] = cur.data;
    if (rst) begin
      age = 0; exp_addr = '0; exp_rsp_id = 1'b0; exp_rsp_rdata = '0;
      last_gnt = 1'b1; exp_q.delete();
    end else if (model_hs) begin
      age = 1; exp_addr = cur.addr;
      last_gnt = cur.id;
    end else if (age == 1) begin
      age = 2;
    end else if (age == 2) begin
      age = 3; exp_rsp_id = cur.id; exp_rsp_rdata = exp_q.pop_front();
    end else if (age == 3) begin
      age = 0;
    end
    rst_prev = rst;
    cyc++;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int n, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  task automatic set_rand(input int n, input logic v);
    set_req(n, v, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
            DW'($urandom_range(0, 255)));
  endtask

  // Tick until the model accepts a request; an expired budget is a failure.
  task automatic wait_hs(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!model_hs && n < 20);
    if (!model_hs) chk({tag, "_timeout"}, 32'(0), 32'(1));
  endtask

  // One transaction from a single requester; junk (ignored) requests follow.
  task automatic txn(input int id, input logic we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    set_req(id, 1'b1, we, a, d);
    set_req(1 - id, 1'b0, 1'b0, '0, '0);
    wait_hs("txn");
    for (int i = 0; i < 3; i++) begin
      set_rand(0, 1'b1);
      set_rand(1, 1'b1);
      tick();
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    age = 0; last_gnt = 1'b1; exp_addr = '0; exp_rsp_id = 1'b0; exp_rsp_rdata = '0;
    rst_prev = 1'b0; model_hs = 1'b0;
    cur = '{id: 1'b0, we: 1'b0, addr: '0, data: '0};
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    ram_clear = 1'b1;
    @(negedge clk);

    // Reset: held three cycles, reset values checked on the later ones.
    tick();
    ram_clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Single write, then readback by the other requester.
    txn(0, 1'b1, 4'h3, 8'hA5);
    txn(1, 1'b0, 4'h3, 8'h00);
    chk("readback_rdata", 32'(bus.rsp_rdata), 32'(8'hA5));
    chk("readback_id", 32'(bus.rsp_id), 32'(1));

    // Conflict: both requesters valid for three transactions.
    dut_gnt.delete();
    for (int i = 0; i < 12; i++) begin
      set_rand(0, 1'b1);
      set_rand(1, 1'b1);
      tick();
    end
    chk("conflict_count", 32'(dut_gnt.size()), 32'(3));
    if (dut_gnt.size() == 3) begin
      chk("conflict_g0", 32'(dut_gnt[0]), 32'(0));
      chk("conflict_g1", 32'(dut_gnt[1]), 32'(RR ? 1 : 0));
      chk("conflict_g2", 32'(dut_gnt[2]), 32'(0));
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) tick();

    // Full sweep with valid held continuously: writes via 0, reads via 1.
    dut_hs_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      set_req(0, 1'b1, 1'b1, AW'(i), DW'(i));
      wait_hs("sweep_wr");
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 16; i++) begin
      set_req(1, 1'b1, 1'b0, AW'(i), '0);
      wait_hs("sweep_rd");
      if (i > 0) chk("sweep_prev_rdata", 32'(bus.rsp_rdata), 32'(i - 1));
    end
    set_req(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) tick();
    chk("sweep_last_rdata", 32'(bus.rsp_rdata), 32'(15));
    chk("sweep_hs_count", 32'(dut_hs_cyc.size()), 32'(32));
    for (int i = 1; i < dut_hs_cyc.size(); i++)
      chk("sweep_hs_spacing", 32'(dut_hs_cyc[i] - dut_hs_cyc[i-1]), 32'(4));

    // Random traffic on both requesters.
    for (int i = 0; i < 120; i++) begin
      set_rand(0, 1'($urandom_range(0, 1)));
      set_rand(1, 1'($urandom_range(0, 1)));
      tick();
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) tick();

    // Reset during the ACCESS cycle of a write to address 7.
    set_req(0, 1'b1, 1'b1, 4'h7, DW'($urandom_range(0, 255)));
    wait_hs("rst_wr");
    set_req(0, 1'b0, 1'b0, '0, '0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_strobe_we", 32'(ram_we), 32'(0));
    chk("rst_strobe_en", 32'(ram_enable), 32'(0));
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    set_rand(0, 1'b1);
    set_rand(1, 1'b1);
    dut_gnt.delete();
    wait_hs("post_rst_conflict");
    chk("post_rst_grant", 32'(dut_gnt.size() > 0 ? dut_gnt[0] : 9), 32'(0));
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, RAM address width (16 words).
REQ-002 Parameter DATA_W, default 8, RAM word width.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req0_valid / req1_valid  input  1  requester N has a transaction pending.
REQ-007 req0_we / req1_we  input  1  1 = write, 0 = read.
REQ-008 req0_addr / req1_addr  input  ADDR_W  target word.
REQ-009 req0_wdata / req1_wdata  input  DATA_W  write data.
REQ-010 req0_ready / req1_ready  output  1  request accepted this cycle; combinational.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_id  output  1  requester that owns the completion.
REQ-013 rsp_rdata  output  DATA_W  read data; 0 for writes.
REQ-014 ram_we, ram_enable  output  1  RAM strobes: write = we=1, enable=0; read = we=0, enable=1.
REQ-015 ram_addr  output  ADDR_W  RAM address.
REQ-016 ram_data  inout  DATA_W  RAM data bus; driven only when ram_we=1 and ram_enable=0, otherwise high-Z.

Function
REQ-017 The FSM SHALL have four states: IDLE, SETUP, ACCESS and RESP, with transitions IDLE->SETUP on handshake, then SETUP->ACCESS->RESP->IDLE unconditionally.
REQ-018 reqN_ready SHALL be high only in IDLE for the granted requester; a handshake is reqN_valid and reqN_ready in cycle T.
REQ-019 On handshake, we, addr, wdata and id SHALL be latched; requester inputs are then ignored until IDLE.
REQ-020 SETUP (T+1): ram_addr SHALL be valid with both strobes low.
REQ-021 ACCESS (T+2): the matching strobe SHALL be high for exactly one cycle; for a read, ram_data SHALL be sampled at the end of the cycle.
REQ-022 RESP (T+3): rsp_valid=1, rsp_id and rsp_rdata valid for one cycle; sustained throughput is one transaction per 4 cycles.
REQ-023 ram_addr SHALL be held from SETUP through RESP, and no strobe SHALL change in the same cycle as an address change.
REQ-024 When both requesters are valid in IDLE, the grant SHALL follow the policy in the Configuration section.
REQ-025 When only one requester is valid, it SHALL be granted regardless of policy.
REQ-026 All outputs except reqN_ready SHALL be registered.
REQ-027 Address 15 and data 8'hFF SHALL need no special handling (full range, no wrap logic).

Reset
REQ-028 While rst=1: state=IDLE, ram_we=0, ram_enable=0, ram_addr=0, ram_data high-Z, rsp_valid=0, rsp_id=0, rsp_rdata=0, req0_ready=req1_ready=0.
REQ-029 If rst is asserted mid-transaction, the transaction SHALL be dropped with no rsp_valid, and strobes SHALL be low from the next cycle.
REQ-030 The round-robin pointer SHALL reset to "last granted = 1", so requester 0 wins the first conflict.

Configuration
REQ-031 With RAM_ARB_RR_EN defined, conflicts SHALL be resolved round-robin: the requester not granted last wins, and the pointer updates on each handshake.
REQ-032 Without RAM_ARB_RR_EN, requester 0 SHALL always win a conflict and no pointer register SHALL exist.

Structure
REQ-033 A shared package ram_arb_pkg SHALL hold the FSM state enum (IDLE/SETUP/ACCESS/RESP), ADDR_W/DATA_W defaults and the strobe encodings.
REQ-034 Grant selection SHALL be a sub-module ram_arb_grant (inputs: two valids, pointer; output: one-hot grant).
REQ-035 The RAM itself SHALL be external; ram_arbiter SHALL connect to it by ports only.

Verification
REQ-036 Single write: req0 writes addr 4'h3, data 8'hA5 -> ram_we high only at T+2, ram_data=8'hA5 at T+2; rsp_valid at T+3 with rsp_id=0.
REQ-037 Readback: req1 reads addr 4'h3 after REQ-036 -> ram_enable high at T+2, ram_data undriven by the arbiter; at T+3 rsp_id=1 and rsp_rdata=8'hA5.
REQ-038 Conflict, both valid continuously with RR enabled: grants alternate 0,1,0,1; without the macro, grants are 0,0,0.
REQ-039 Full sweep: write addr=data for addresses 0..15 via req0, then read 0..15 via req1 -> each rsp_rdata equals its address; handshakes are 4 cycles apart.
REQ-040 Reset in ACCESS during a write to 4'h7 -> no rsp_valid, strobes 0 the next cycle, ram_data high-Z; the first conflict after reset grants requester 0.
